barrel_shift_arbiter: RTL

BARREL_SHIFT_ARBITER -- requirements
Module: barrel_shift_arbiter

---
 rtl/barrel_shift_arbiter.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/barrel_shift_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : barrel_shift_arbiter
// Purpose  : Two requesters share one 8-bit rotate-left datapath. An IDLE ->
//            SHIFT -> HOLD FSM keeps exactly one job in flight. In IDLE one
//            requester is granted and its ready is raised combinationally.
//            SHIFT registers the rotated result. HOLD presents it until the
//            consumer takes it.
// Ports    : clk, rst_n (async, active-low)
//            req0_valid/req0_a/req0_range -> req0_ready  (requester 0)
//            req1_valid/req1_a/req1_range -> req1_ready  (requester 1)
//            resp_valid/resp_data/resp_id <- resp_ready   (response)
//            busy      : FSM is not in IDLE
//            xfer_cnt  : completed-response count, wraps 255 -> 0
// Macro    : BSA_ROUND_ROBIN_EN -- when defined, simultaneous requests are
//            granted round-robin. Otherwise requester 0 has fixed priority.
// Revision : 1.0 initial release
// ============================================================================
module barrel_shift_arbiter (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       req0_valid,
   input  logic [7:0] req0_a,
   input  logic [2:0] req0_range,
   output logic       req0_ready,
   input  logic       req1_valid,
   input  logic [7:0] req1_a,
   input  logic [2:0] req1_range,
   output logic       req1_ready,
   output logic       resp_valid,
   input  logic       resp_ready,
   output logic [7:0] resp_data,
   output logic       resp_id,
   output logic       busy,
   output logic [7:0] xfer_cnt
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_HOLD  = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [7:0]  a_q, a_d;
   logic [2:0]  range_q, range_d;
   logic        id_q, id_d;
   logic        resp_valid_q, resp_valid_d;
   logic [7:0]  resp_data_q, resp_data_d;
   logic        resp_id_q, resp_id_d;
   logic [7:0]  xfer_cnt_q, xfer_cnt_d;

   logic        w_prefer1;
   logic        w_gnt0;
   logic        w_gnt1;
   logic        w_ready0;
   logic        w_ready1;
   logic [15:0] w_rot_wide;

`ifdef BSA_ROUND_ROBIN_EN
   logic        last_grant_q, last_grant_d;

   // Requester 1 wins a tie only when requester 0 took the previous grant.
   assign w_prefer1 = (last_grant_q == 1'b0);
`else
   assign w_prefer1 = 1'b0;
`endif

   // Grants are suppressed while reset is held so both readies read 0.
   assign w_gnt1 = rst_n && req1_valid && (!req0_valid || w_prefer1);
   assign w_gnt0 = rst_n && req0_valid && !w_gnt1;

   // Rotating the doubled operand left puts the rotated byte in the top half.
   assign w_rot_wide = {a_q, a_q} << range_q;

   always_comb begin
      state_d      = state_q;
      a_d          = a_q;
      range_d      = range_q;
      id_d         = id_q;
      resp_valid_d = resp_valid_q;
      resp_data_d  = resp_data_q;
      resp_id_d    = resp_id_q;
      xfer_cnt_d   = xfer_cnt_q;
      w_ready0     = 1'b0;
      w_ready1     = 1'b0;
`ifdef BSA_ROUND_ROBIN_EN
      last_grant_d = last_grant_q;
`endif
      unique case (state_q)
         ST_IDLE: begin
            if (w_gnt0 || w_gnt1) begin
               w_ready0 = w_gnt0;
               w_ready1 = w_gnt1;
               a_d      = w_gnt1 ? req1_a : req0_a;
               range_d  = w_gnt1 ? req1_range : req0_range;
               id_d     = w_gnt1;
               state_d  = ST_SHIFT;
`ifdef BSA_ROUND_ROBIN_EN
               last_grant_d = w_gnt1;
`endif
            end
         end
         ST_SHIFT: begin
            resp_data_d  = w_rot_wide[15:8];
            resp_id_d    = id_q;
            resp_valid_d = 1'b1;
            state_d      = ST_HOLD;
         end
         ST_HOLD: begin
            if (resp_ready) begin
               resp_valid_d = 1'b0;
               xfer_cnt_d   = xfer_cnt_q + 8'd1;
               state_d      = ST_IDLE;
            end
         end
         default: begin
            state_d      = ST_IDLE;
            resp_valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         a_q          <= 8'h00;
         range_q      <= 3'd0;
         id_q         <= 1'b0;
         resp_valid_q <= 1'b0;
         resp_data_q  <= 8'h00;
         resp_id_q    <= 1'b0;
         xfer_cnt_q   <= 8'h00;
`ifdef BSA_ROUND_ROBIN_EN
         last_grant_q <= 1'b1;
`endif
      end else begin
         state_q      <= state_d;
         a_q          <= a_d;
         range_q      <= range_d;
         id_q         <= id_d;
         resp_valid_q <= resp_valid_d;
         resp_data_q  <= resp_data_d;
         resp_id_q    <= resp_id_d;
         xfer_cnt_q   <= xfer_cnt_d;
`ifdef BSA_ROUND_ROBIN_EN
         last_grant_q <= last_grant_d;
`endif
      end
   end

   assign req0_ready = w_ready0;
   assign req1_ready = w_ready1;
   assign resp_valid = resp_valid_q;
   assign resp_data  = resp_data_q;
   assign resp_id    = resp_id_q;
   assign busy       = (state_q != ST_IDLE);
   assign xfer_cnt   = xfer_cnt_q;

endmodule
`default_nettype wire
